// File: rtl/cpu_prefetch_unit_if.sv
// ---------------------------------------------------------------------------
// cpu_prefetch_unit_if : memory-bus and core-fetch signals of the prefetcher
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cpu_prefetch_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_rd;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ready;
  logic                  bus_grant;
  logic                  halt;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] flush_pc;
  logic                  fetch_pop;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [LVL_W-1:0]      level;

  // master: the prefetch unit itself
  modport master (
    output bus_addr, bus_rd, fetch_valid, fetch_data, fetch_pc, level,
    input  bus_rdata, bus_ready, bus_grant, halt, flush, flush_pc, fetch_pop
  );

  // slave: memory and core decoder around the prefetcher
  modport slave (
    input  bus_addr, bus_rd, fetch_valid, fetch_data, fetch_pc, level,
    output bus_rdata, bus_ready, bus_grant, halt, flush, flush_pc, fetch_pop
  );
endinterface

`default_nettype wire

// File: rtl/cpu_prefetch_unit.sv
// ---------------------------------------------------------------------------
// cpu_prefetch_unit : DEPTH-entry speculative instruction-byte prefetch queue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_prefetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h2000
) (
  input  logic                clk,
  input  logic                reset,
  cpu_prefetch_unit_if.master pf
);
  localparam int               PTR_W     = $clog2(DEPTH);
  localparam int               LVL_W     = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_bus_rd;
  logic                  w_bus_rd_nxt;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [ADDR_WIDTH-1:0] w_bus_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_addr;
  logic [ADDR_WIDTH-1:0] w_fetch_addr_nxt;
  logic [ADDR_WIDTH-1:0] w_fetch_addr_inc;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [LVL_W-1:0]      r_level;
  logic [LVL_W-1:0]      w_level_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_abort;
  logic w_push;
  logic w_pop;
  logic w_issue;

  // An abort wins over a completing read, so data returned on that edge is dropped.
  assign w_abort          = (r_state == S_REQ) && (!pf.bus_grant || pf.halt);
  assign w_push           = (r_state == S_REQ) && pf.bus_ready && !w_abort && !pf.flush;
  assign w_pop            = pf.fetch_pop && (r_level != '0) && !pf.flush;
  assign w_level_nxt      = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
  assign w_issue          = pf.bus_grant && !pf.halt && !pf.flush && (w_level_nxt < DEPTH_LVL);
  assign w_fetch_addr_inc = r_fetch_addr + ADDR_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_bus_rd     <= 1'b0;
      r_bus_addr   <= RESET_PC;
      r_fetch_addr <= RESET_PC;
    end else begin
      r_state      <= w_state_nxt;
      r_bus_rd     <= w_bus_rd_nxt;
      r_bus_addr   <= w_bus_addr_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bus_rd_nxt     = r_bus_rd;
    w_bus_addr_nxt   = r_bus_addr;
    w_fetch_addr_nxt = r_fetch_addr;
    if (pf.flush) begin
      w_state_nxt      = S_IDLE;
      w_bus_rd_nxt     = 1'b0;
      w_fetch_addr_nxt = pf.flush_pc;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            w_state_nxt    = S_REQ;
            w_bus_rd_nxt   = 1'b1;
            w_bus_addr_nxt = r_fetch_addr;
          end
        end
        S_REQ: begin
          if (w_abort) begin
            w_state_nxt  = S_IDLE;
            w_bus_rd_nxt = 1'b0;
          end else if (pf.bus_ready) begin
            w_fetch_addr_nxt = w_fetch_addr_inc;
            if (w_issue) begin
              w_bus_addr_nxt = w_fetch_addr_inc;
            end else begin
              w_state_nxt  = S_IDLE;
              w_bus_rd_nxt = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_bus_rd_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_fetch_pc <= RESET_PC;
    end else if (pf.flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_fetch_pc <= pf.flush_pc;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr     <= r_rptr + PTR_W'(1);
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
      end
      r_level <= w_level_nxt;
    end
  end

  // Storage needs no reset: entries are only visible once level covers them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= pf.bus_rdata;
    end
  end

  assign pf.bus_rd      = r_bus_rd;
  assign pf.bus_addr    = r_bus_addr;
  assign pf.fetch_valid = (r_level != '0);
  assign pf.fetch_data  = r_mem[r_rptr];
  assign pf.fetch_pc    = r_fetch_pc;
  assign pf.level       = r_level;

endmodule

`default_nettype wire

// File: tb/tb_cpu_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_cpu_prefetch_unit : directed scoreboard bench for cpu_prefetch_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_prefetch_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] waits;
  logic [3:0] wcnt;
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [15:0] exp_rd  [$];
  logic [15:0] exp_pc  [$];
  logic [7:0]  exp_dat [$];

  cpu_prefetch_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(4)) pif ();

  cpu_prefetch_unit #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .DEPTH     (4),
    .RESET_PC  (16'h2000)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .pf   (pif)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Memory model: ready after 'waits' extra cycles of a held request.
  assign pif.bus_ready = pif.bus_rd && (wcnt >= waits);
  assign pif.bus_rdata = mem_byte(pif.bus_addr);

  always @(posedge clk or posedge reset) begin
    if (reset)                              wcnt <= 4'd0;
    else if (!pif.bus_rd || pif.bus_ready)  wcnt <= 4'd0;
    else                                    wcnt <= wcnt + 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_read(input logic [15:0] a);
    exp_rd.push_back(a);
  endtask

  task automatic exp_fetch(input logic [15:0] a);
    exp_pc.push_back(a);
    exp_dat.push_back(mem_byte(a));
  endtask

  // Monitor: accepted bus reads and core pops are checked against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (pif.bus_rd && pif.bus_ready && pif.bus_grant && !pif.halt && !pif.flush) begin
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: actual=%0h expected=none", pif.bus_addr);
        end else begin
          chk("read_addr", 32'(pif.bus_addr), 32'(exp_rd.pop_front()));
        end
      end
      if (pif.fetch_pop && pif.fetch_valid && !pif.flush) begin
        if (exp_pc.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: actual=%0h expected=none", pif.fetch_pc);
        end else begin
          chk("pop_pc",   32'(pif.fetch_pc),   32'(exp_pc.pop_front()));
          chk("pop_data", 32'(pif.fetch_data), 32'(exp_dat.pop_front()));
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    waits          = 4'd0;
    pif.bus_grant  = 1'b1;
    pif.halt       = 1'b0;
    pif.flush      = 1'b0;
    pif.flush_pc   = 16'h0000;
    pif.fetch_pop  = 1'b0;
    step(2);

    chk("rst_bus_rd",   32'(pif.bus_rd),      32'd0);
    chk("rst_bus_addr", 32'(pif.bus_addr),    32'h2000);
    chk("rst_fetch_pc", 32'(pif.fetch_pc),    32'h2000);
    chk("rst_level",    32'(pif.level),       32'd0);
    chk("rst_valid",    32'(pif.fetch_valid), 32'd0);

    // Fill from reset, zero wait states
    for (int i = 0; i < 4; i++) exp_read(16'h2000 + 16'(i));
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("fill_rd",   32'(pif.bus_rd),   32'd1);
      chk("fill_addr", 32'(pif.bus_addr), 32'(16'h2000 + 16'(i)));
    end
    step(1);
    chk("full_level", 32'(pif.level),      32'd4);
    chk("full_rd",    32'(pif.bus_rd),     32'd0);
    chk("full_data",  32'(pif.fetch_data), 32'(mem_byte(16'h2000)));
    chk("full_pc",    32'(pif.fetch_pc),   32'h2000);

    // Pop every cycle from a full queue
    for (int i = 0; i < 8; i++) begin
      exp_fetch(16'h2000 + 16'(i));
      exp_read(16'h2004 + 16'(i));
    end
    pif.fetch_pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("stream_level", 32'(pif.level), 32'd3);
    end
    pif.fetch_pop = 1'b0;
    step(1);
    chk("stream_refill", 32'(pif.level),    32'd4);
    chk("stream_pc",     32'(pif.fetch_pc), 32'h2008);

    // Two wait states, then flush during a waited read at 0x2002
    reset = 1'b1;
    waits = 4'd2;
    step(1);
    reset = 1'b0;
    exp_read(16'h2000);
    exp_read(16'h2001);
    step(1);
    chk("ws_rd",   32'(pif.bus_rd),   32'd1);
    chk("ws_addr", 32'(pif.bus_addr), 32'h2000);
    for (int k = 0; k < 2; k++) begin
      step(2);
      chk("ws_hold_addr",  32'(pif.bus_addr), 32'(16'h2000 + 16'(k)));
      chk("ws_hold_level", 32'(pif.level),    32'(k));
      step(1);
      chk("ws_level",      32'(pif.level),    32'(k + 1));
    end
    step(2);
    chk("fl_pre_rd",   32'(pif.bus_rd),   32'd1);
    chk("fl_pre_addr", 32'(pif.bus_addr), 32'h2002);
    pif.flush    = 1'b1;
    pif.flush_pc = 16'h3000;
    step(1);
    chk("fl_rd",    32'(pif.bus_rd),      32'd0);
    chk("fl_level", 32'(pif.level),       32'd0);
    chk("fl_valid", 32'(pif.fetch_valid), 32'd0);
    chk("fl_pc",    32'(pif.fetch_pc),    32'h3000);
    pif.flush = 1'b0;
    waits     = 4'd0;
    for (int i = 0; i < 4; i++) exp_read(16'h3000 + 16'(i));
    step(1);
    chk("fl_new_rd",   32'(pif.bus_rd),   32'd1);
    chk("fl_new_addr", 32'(pif.bus_addr), 32'h3000);
    step(1);
    chk("fl_first_level", 32'(pif.level),      32'd1);
    chk("fl_first_data",  32'(pif.fetch_data), 32'(mem_byte(16'h3000)));
    step(3);
    chk("fl_full_level", 32'(pif.level),  32'd4);
    chk("fl_full_rd",    32'(pif.bus_rd), 32'd0);

    // Grant loss mid-read at 0x2001, then halt mid-read at 0x2002 with a pop
    reset = 1'b1;
    waits = 4'd2;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) exp_read(16'h2000 + 16'(i));
    step(4);
    chk("gr_level", 32'(pif.level),    32'd1);
    chk("gr_addr",  32'(pif.bus_addr), 32'h2001);
    step(1);
    pif.bus_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("gr_abort_rd", 32'(pif.bus_rd), 32'd0);
    end
    pif.bus_grant = 1'b1;
    step(1);
    chk("gr_reissue_rd",   32'(pif.bus_rd),   32'd1);
    chk("gr_reissue_addr", 32'(pif.bus_addr), 32'h2001);
    step(3);
    chk("gr_after_level", 32'(pif.level),    32'd2);
    chk("gr_after_addr",  32'(pif.bus_addr), 32'h2002);
    step(1);
    exp_fetch(16'h2000);
    pif.halt      = 1'b1;
    pif.fetch_pop = 1'b1;
    step(1);
    pif.fetch_pop = 1'b0;
    chk("ht_rd",    32'(pif.bus_rd),   32'd0);
    chk("ht_pc",    32'(pif.fetch_pc), 32'h2001);
    chk("ht_level", 32'(pif.level),    32'd1);
    step(2);
    chk("ht_hold_rd",    32'(pif.bus_rd), 32'd0);
    chk("ht_hold_level", 32'(pif.level),  32'd1);
    pif.halt = 1'b0;
    waits    = 4'd0;
    step(1);
    chk("ht_reissue_rd",   32'(pif.bus_rd),   32'd1);
    chk("ht_reissue_addr", 32'(pif.bus_addr), 32'h2002);
    step(3);
    chk("ht_full_level", 32'(pif.level), 32'd4);
    for (int i = 1; i < 5; i++) exp_fetch(16'h2000 + 16'(i));
    pif.bus_grant = 1'b0;
    pif.fetch_pop = 1'b1;
    step(4);
    chk("drain_level", 32'(pif.level),       32'd0);
    chk("drain_valid", 32'(pif.fetch_valid), 32'd0);
    step(1);
    pif.fetch_pop = 1'b0;
    chk("empty_pop_pc",    32'(pif.fetch_pc), 32'h2005);
    chk("empty_pop_level", 32'(pif.level),    32'd0);

    // Address wrap from 0xFFFE, then asynchronous reset mid-read
    pif.flush     = 1'b1;
    pif.flush_pc  = 16'hFFFE;
    pif.bus_grant = 1'b1;
    exp_read(16'hFFFE);
    exp_read(16'hFFFF);
    exp_read(16'h0000);
    exp_read(16'h0001);
    step(1);
    chk("wr_flush_pc", 32'(pif.fetch_pc), 32'hFFFE);
    pif.flush = 1'b0;
    step(1);
    chk("wr_addr0", 32'(pif.bus_addr), 32'hFFFE);
    step(2);
    chk("wr_addr2", 32'(pif.bus_addr), 32'h0000);
    step(2);
    chk("wr_level", 32'(pif.level),  32'd4);
    chk("wr_rd",    32'(pif.bus_rd), 32'd0);
    exp_fetch(16'hFFFE);
    exp_fetch(16'hFFFF);
    pif.bus_grant = 1'b0;
    pif.fetch_pop = 1'b1;
    step(2);
    pif.fetch_pop = 1'b0;
    chk("wr_pc",   32'(pif.fetch_pc),   32'h0000);
    chk("wr_data", 32'(pif.fetch_data), 32'(mem_byte(16'h0000)));
    pif.bus_grant = 1'b1;
    waits         = 4'd2;
    step(1);
    chk("ar_pre_rd",   32'(pif.bus_rd),   32'd1);
    chk("ar_pre_addr", 32'(pif.bus_addr), 32'h0002);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_rd",    32'(pif.bus_rd), 32'd0);
    chk("ar_level", 32'(pif.level),  32'd0);

    chk("left_reads", 32'(exp_rd.size()), 32'd0);
    chk("left_pops",  32'(exp_pc.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
